// File: rtl/freq_meter_if.sv
// Result/control bundle between freq_meter and its host.
//   start        host -> meter   one-cycle measurement request
//   cont         host -> meter   continuous (auto-restart) mode
//   result_ack   host -> meter   consumer has taken the result
//   busy         meter -> host   measurement window or latch in progress
//   result       meter -> host   edge count of the last completed gate
//   result_valid meter -> host   result held, awaiting ack
//   sat          meter -> host   last gate saturated the counter
//   overrun      meter -> host   sticky: unacked result was overwritten
interface freq_meter_if #(
  parameter int CNT_W = 26
);
  logic             start;
  logic             cont;
  logic             result_ack;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             sat;
  logic             overrun;

  modport master (
    input  start, cont, result_ack,
    output busy, result, result_valid, sat, overrun
  );

  modport slave (
    output start, cont, result_ack,
    input  busy, result, result_valid, sat, overrun
  );
endinterface

// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of an asynchronous input over a gate
// window of GATE_CYCLES clk cycles and hands the count to a consumer over a
// valid/ack handshake. Single-shot (start) or continuous (cont) operation.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   sig_in  measured signal, asynchronous to clk
//   bus     freq_meter_if master modport (start/cont/ack in, result/status out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start or cont
// ST_GATE  | counting edges for GATE_CYCLES cycles
// ST_LATCH | one cycle: publish count, then restart (cont) or go idle
module freq_meter #(
  parameter int GATE_CYCLES = 60000000,
  parameter int CNT_W       = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sig_in,
  freq_meter_if.master    bus
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GATE  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [GW-1:0]          gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   gate_sat;
  logic [CNT_W-1:0]       result_q;
  logic                   valid_q;
  logic                   sat_q;
  logic                   overrun_q;

  logic edge_det;
  logic gate_last;
  logic cnt_max;

  assign edge_det  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign gate_last = (gate_cnt == GW'(GATE_CYCLES - 1));
  assign cnt_max   = &edge_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      gate_sat  <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // Ack clears valid; a LATCH in the same cycle overrides below so the
      // fresh result stays valid.
      if (valid_q && bus.result_ack) valid_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.start || bus.cont) begin
            state    <= ST_GATE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            gate_sat <= 1'b0;
          end
        end
        ST_GATE: begin
          gate_cnt <= gate_cnt + GW'(1);
          if (edge_det) begin
            if (cnt_max) gate_sat <= 1'b1;
            else         edge_cnt <= edge_cnt + CNT_W'(1);
          end
          if (gate_last) state <= ST_LATCH;
        end
        ST_LATCH: begin
          result_q <= edge_cnt;
          sat_q    <= gate_sat;
          valid_q  <= 1'b1;
          if (valid_q && !bus.result_ack) overrun_q <= 1'b1;
          if (bus.cont) begin
            state    <= ST_GATE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            gate_sat <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state == ST_GATE) || (state == ST_LATCH);
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.sat          = sat_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Measures the frequency of the divided clock produced by the frequency-divider stage, which arrives on uo_out[0]. It counts rising edges of that signal over a fixed gate window of GATE_CYCLES system clocks (default 1 s at 60 MHz), so the result is in Hz. The result is presented to a downstream consumer with a valid/ack handshake. It runs single-shot or continuously, and flags saturation and unacknowledged overwrites.

Parameters:
GATE_CYCLES, 60000000, gate window length in clk cycles (min 2)
CNT_W, 26, width of the edge counter and result
SYNC_STAGES, 2, synchronizer depth on sig_in (min 2)

Ports:
clk  input  1  system clock (60 MHz)
rst  input  1  synchronous active-high reset
sig_in  input  1  measured signal (divider output); treated as asynchronous
start  input  1  one-cycle request for a measurement; honoured only in IDLE
cont  input  1  continuous mode: auto-restart the gate after each LATCH
result_ack  input  1  consumer acknowledges result
busy  output  1  high in GATE and LATCH
result  output  CNT_W  edge count of last completed gate
result_valid  output  1  result held, awaiting ack
sat  output  1  last completed gate saturated the counter
overrun  output  1  sticky: result overwritten while valid and unacked

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. Reset takes priority over all other inputs.
- Reset values: all outputs 0; state IDLE; gate_cnt, edge_cnt and synchronizer flops 0.
- Edge detection: sig_in passes through SYNC_STAGES flops, plus one history flop.
  - edge = sync_out & ~hist.
  - The first edge can be detected SYNC_STAGES+1 cycles after the sig_in transition.
- IDLE:
  - start=1 or cont=1 -> GATE on the next cycle; gate_cnt and edge_cnt clear to 0 on entry.
  - busy=0.
- GATE:
  - Lasts exactly GATE_CYCLES cycles; gate_cnt runs 0 to GATE_CYCLES-1.
  - edge_cnt increments on every cycle in GATE with edge=1.
  - edge_cnt saturates at 2^CNT_W-1; gate_sat is set when an edge arrives while the counter is already at max.
  - The cycle with gate_cnt==GATE_CYCLES-1 -> LATCH.
- LATCH (one cycle):
  - result<=edge_cnt, sat<=gate_sat, result_valid<=1.
  - If result_valid=1 and result_ack=0 in this cycle, overrun<=1.
  - Next state: cont=1 -> GATE (counters cleared); else IDLE.
- Latency: start sampled at cycle N -> GATE cycles N+1..N+GATE_CYCLES -> LATCH at N+GATE_CYCLES+1 -> result_valid visible at N+GATE_CYCLES+2.
- Handshake:
  - result_ack=1 while result_valid=1 -> result_valid=0 the next cycle.
  - result holds its value until the next LATCH.
  - Ack while result_valid=0 is ignored.
- Simultaneous events:
  - LATCH with result_ack=1 in the same cycle: the new result is loaded, result_valid stays 1, no overrun.
  - start while busy is ignored.
  - cont dropping mid-GATE: the current gate completes, then IDLE.
  - cont changes take effect only in IDLE and LATCH.
- overrun clears only on rst.
- No edge-counter state crosses gates; every GATE entry starts from 0.
- Reset mid-GATE or mid-LATCH: measurement discarded, all outputs back to reset values on the next cycle.

Test Plan:
- GATE_CYCLES=100; sig_in square wave, period 10 clk, any phase; pulse start -> result=10, sat=0, result_valid rises exactly 102 cycles after start sampled, busy high for 101 cycles.
- GATE_CYCLES=100; sig_in held 0, then held 1 -> result=0 both times. A 0->1 step landing inside the gate -> result=1.
- CNT_W=4, GATE_CYCLES=100, sig_in period 4 -> result=15, sat=1. Next gate with period 10 -> result=10, sat=0.
- cont=1, GATE_CYCLES=50, sig_in period 5, no ack -> first result=10 with overrun=0; second LATCH sets overrun=1. Ack the second result, then rst -> overrun=0.
- result_ack asserted exactly in the LATCH cycle of a continuous run -> new result loaded, result_valid stays 1, overrun stays 0. Ack in IDLE with result_valid=0 -> no effect.
- rst pulsed at gate_cnt=40 of a 100-cycle gate -> next cycle state IDLE, busy=0, result=0, result_valid=0. A following start yields a correct full measurement.
